// File: rtl/breakout_debug_pkg.sv
// rtl/breakout_debug_pkg.sv - shared scan states, IR encodings and DR width for the debug scan master
package breakout_debug_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_UIR  = 3'd1,
    ST_CDR  = 3'd2,
    ST_SDR  = 3'd3,
    ST_UDR  = 3'd4
  } scan_state_t;

  localparam logic [1:0] IR_OCIMEM_A = 2'd0;
  localparam logic [1:0] IR_OCIMEM_B = 2'd1;
  localparam logic [1:0] IR_BREAK    = 2'd2;
  localparam logic [1:0] IR_TRACE    = 2'd3;

  localparam int DR_WIDTH_DEFAULT = 38;

endpackage

// File: rtl/breakout_debug_tck_gen.sv
// rtl/breakout_debug_tck_gen.sv - tck divider; flags the clk edges that make tck rise and fall
module breakout_debug_tck_gen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic tck,
  output logic rise_pulse,
  output logic fall_pulse
);

  logic [7:0] cnt;
  logic       wrap;

  // Counter and tck are parked at 0 while idle so every scan starts phase-aligned.
  assign wrap       = run && (cnt == 8'(TCK_DIV - 1));
  assign rise_pulse = wrap && !tck;
  assign fall_pulse = wrap && tck;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (!run) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (wrap) begin
      cnt <= '0;
      tck <= ~tck;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/breakout_processor_cpu_debug_scan_master.sv
// rtl/breakout_processor_cpu_debug_scan_master.sv - virtual JTAG scan master; IR-skip option under DEBUG_SCAN_SKIP_IR_EN
module breakout_processor_cpu_debug_scan_master
  import breakout_debug_pkg::*;
#(
  parameter int TCK_DIV  = 2,
  parameter int DR_WIDTH = DR_WIDTH_DEFAULT
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [1:0]          vji_ir_in,
  output logic                vji_rti,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr
);

  localparam int CW = $clog2(DR_WIDTH + 1);

  scan_state_t         state, state_next;
  logic                tck_rise, tck_fall;
  logic                accept, skip_ir, last_bit;
  logic [CW-1:0]       bit_cnt;
  logic [DR_WIDTH-1:0] shift_out, capture;

  assign accept   = cmd_valid && cmd_ready;
  assign last_bit = (bit_cnt == CW'(DR_WIDTH - 1));

  breakout_debug_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
    .clk        (clk),
    .reset_n    (reset_n),
    .run        (state != ST_IDLE),
    .tck        (vji_tck),
    .rise_pulse (tck_rise),
    .fall_pulse (tck_fall)
  );

`ifdef DEBUG_SCAN_SKIP_IR_EN
  // vji_ir_in already holds the last issued IR; this flag only blocks a skip before the first scan.
  logic ir_issued;
  assign skip_ir = ir_issued && (cmd_ir == vji_ir_in);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    ir_issued <= 1'b0;
    else if (accept) ir_issued <= 1'b1;
  end
`else
  assign skip_ir = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (cmd_valid)            state_next = skip_ir ? ST_CDR : ST_UIR;
      ST_UIR:  if (tck_fall)             state_next = ST_CDR;
      ST_CDR:  if (tck_fall)             state_next = ST_SDR;
      ST_SDR:  if (tck_fall && last_bit) state_next = ST_UDR;
      ST_UDR:  if (tck_fall)             state_next = ST_IDLE;
      default:                           state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    vji_rti   = 1'b0;
    vji_uir   = 1'b0;
    vji_cdr   = 1'b0;
    vji_sdr   = 1'b0;
    vji_udr   = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        vji_rti   = 1'b1;
      end
      ST_UIR:  vji_uir = 1'b1;
      ST_CDR:  vji_cdr = 1'b1;
      ST_SDR:  vji_sdr = 1'b1;
      ST_UDR:  vji_udr = 1'b1;
      default: ;
    endcase
  end

  // tdi is launched on falling tck edges, tdo captured on rising ones, MSB-in so bit 0 ends up first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vji_ir_in <= IR_OCIMEM_A;
      vji_tdi   <= 1'b0;
      shift_out <= '0;
      capture   <= '0;
      bit_cnt   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (accept) begin
        shift_out <= cmd_data;
        if (!skip_ir) vji_ir_in <= cmd_ir;
      end
      if (state == ST_CDR && tck_fall) begin
        vji_tdi   <= shift_out[0];
        shift_out <= shift_out >> 1;
        bit_cnt   <= '0;
      end
      if (state == ST_SDR && tck_fall) begin
        if (last_bit) begin
          vji_tdi <= 1'b0;
        end else begin
          vji_tdi   <= shift_out[0];
          shift_out <= shift_out >> 1;
          bit_cnt   <= bit_cnt + CW'(1);
        end
      end
      if (state == ST_SDR && tck_rise) capture <= {vji_tdo, capture[DR_WIDTH-1:1]};
      if (state == ST_UDR && tck_fall) begin
        rsp_valid <= 1'b1;
        rsp_data  <= capture;
      end
    end
  end

endmodule

// File: tb/tb_breakout_processor_cpu_debug_scan_master.sv
// tb/tb_breakout_processor_cpu_debug_scan_master.sv - scoreboard bench: default-divider and TCK_DIV=3 instances
module tb_breakout_processor_cpu_debug_scan_master;

  localparam int DW   = 38;
  localparam int DIV1 = 3;
`ifdef DEBUG_SCAN_SKIP_IR_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    ir;
    int            lat;
    bit            uir;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // instance 0: default divider, loopback or constant-one tdo
  logic          rst0_n = 1'b1, v0 = 1'b0, rdy0, rv0, tck0, tdi0, tdo0;
  logic [1:0]    ir0 = '0, irin0;
  logic [DW-1:0] d0 = '0, rd0;
  logic          rti0, uir0, cdr0, sdr0, udr0;
  logic          lb0 = 1'b0, tdo_one = 1'b0;

  breakout_processor_cpu_debug_scan_master dut0 (
    .clk(clk), .reset_n(rst0_n), .cmd_valid(v0), .cmd_ready(rdy0), .cmd_ir(ir0), .cmd_data(d0),
    .rsp_valid(rv0), .rsp_data(rd0), .vji_tck(tck0), .vji_tdi(tdi0), .vji_tdo(tdo0),
    .vji_ir_in(irin0), .vji_rti(rti0), .vji_uir(uir0), .vji_cdr(cdr0), .vji_sdr(sdr0), .vji_udr(udr0));

  always @(posedge tck0) lb0 <= tdi0;
  assign tdo0 = tdo_one | lb0;

  // instance 1: TCK_DIV=3; tdo carries junk between a tck rise and the following fall
  logic          rst1_n = 1'b1, v1 = 1'b0, rdy1, rv1, tck1, tdi1;
  logic [1:0]    ir1 = '0, irin1;
  logic [DW-1:0] d1 = '0, rd1;
  logic          rti1, uir1, cdr1, sdr1, udr1;
  logic          lb1 = 1'b0, tdo1 = 1'b0;

  breakout_processor_cpu_debug_scan_master #(.TCK_DIV(DIV1)) dut1 (
    .clk(clk), .reset_n(rst1_n), .cmd_valid(v1), .cmd_ready(rdy1), .cmd_ir(ir1), .cmd_data(d1),
    .rsp_valid(rv1), .rsp_data(rd1), .vji_tck(tck1), .vji_tdi(tdi1), .vji_tdo(tdo1),
    .vji_ir_in(irin1), .vji_rti(rti1), .vji_uir(uir1), .vji_cdr(cdr1), .vji_sdr(sdr1), .vji_udr(udr1));

  always @(tck1) begin
    if (tck1) begin
      lb1  <= tdi1;
      tdo1 <= 1'($urandom);
    end else begin
      tdo1 <= lb1;
    end
  end

  exp_t exp_q0[$], exp_q1[$];
  int   acc_q0[$], acc_q1[$];
  exp_t e0, e1;
  int   a0, a1, last_rise1;
  bit   scan0 = 0, rdy_bad0, tdi_bad0 = 0, uir_seen0, hold_bad0 = 0;
  bit   scan1 = 0, rdy_bad1;
  int   rises0;
  logic tck_prev0 = 1'b0, tck_prev1 = 1'b0, tdi_prev1 = 1'b0;
  logic [DW-1:0] rd_last0 = '0;

  always @(negedge clk) begin
    if (!rst0_n) begin
      scan0    = 0;
      rd_last0 = '0;
    end else begin
      chk("onehot0", 64'($onehot({rti0, uir0, cdr0, sdr0, udr0})), 64'd1);
      if (tdi0 && !sdr0) tdi_bad0 = 1;
      if (!rv0 && rd0 !== rd_last0) hold_bad0 = 1;
      if (scan0) begin
        if (rdy0 && !rv0) rdy_bad0 = 1;
        if (uir0) uir_seen0 = 1;
        if (sdr0 && tck0 && !tck_prev0) rises0++;
      end
      if (rv0) begin
        rd_last0 = rd0;
        if (exp_q0.size() == 0 || acc_q0.size() == 0) begin
          chk("unexpected_rsp0", 64'd1, 64'd0);
        end else begin
          e0 = exp_q0.pop_front();
          a0 = acc_q0.pop_front();
          chk("rsp_data0", 64'(rd0), 64'(e0.data));
          chk("latency0", 64'(cyc - a0), 64'(e0.lat));
          chk("uir_seen0", 64'(uir_seen0), 64'(e0.uir));
          chk("ir_in0", 64'(irin0), 64'(e0.ir));
          chk("sdr_periods0", 64'(rises0), 64'(DW));
          chk("ready_low0", 64'(rdy_bad0), 64'd0);
          chk("tdi_outside_sdr0", 64'(tdi_bad0), 64'd0);
          chk("rsp_hold0", 64'(hold_bad0), 64'd0);
        end
        scan0 = 0;
      end
      if (v0 && rdy0) begin
        acc_q0.push_back(cyc + 1);
        scan0 = 1; rdy_bad0 = 0; uir_seen0 = 0; rises0 = 0;
      end
    end
    tck_prev0 = tck0;
  end

  always @(negedge clk) begin
    if (!rst1_n) begin
      scan1 = 0;
    end else begin
      chk("onehot1", 64'($onehot({rti1, uir1, cdr1, sdr1, udr1})), 64'd1);
      if (scan1) begin
        if (rdy1 && !rv1) rdy_bad1 = 1;
        if (tck1 && !tck_prev1) begin
          if (last_rise1 >= 0) chk("tck_period1", 64'(cyc - last_rise1), 64'(2 * DIV1));
          last_rise1 = cyc;
        end
        if (tdi1 !== tdi_prev1) chk("tdi_on_fall1", 64'(tck_prev1 && !tck1), 64'd1);
      end
      if (rv1) begin
        if (exp_q1.size() == 0 || acc_q1.size() == 0) begin
          chk("unexpected_rsp1", 64'd1, 64'd0);
        end else begin
          e1 = exp_q1.pop_front();
          a1 = acc_q1.pop_front();
          chk("rsp_data1", 64'(rd1), 64'(e1.data));
          chk("latency1", 64'(cyc - a1), 64'(e1.lat));
          chk("ir_in1", 64'(irin1), 64'(e1.ir));
          chk("ready_low1", 64'(rdy_bad1), 64'd0);
        end
        scan1 = 0;
      end
      if (v1 && rdy1) begin
        acc_q1.push_back(cyc + 1);
        scan1 = 1; rdy_bad1 = 0; last_rise1 = -1;
      end
    end
    tck_prev1 = tck1;
    tdi_prev1 = tdi1;
  end

  bit       have_ir0 = 0;
  logic [1:0] last_ir0 = '0;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send0(input logic [1:0] ir, input logic [DW-1:0] data, input bit hold, input bit b2b);
    exp_t e;
    int   n = 0;
    v0 = 1'b1; ir0 = ir; d0 = data;
    while (!rdy0 && n < 2000) begin step(); n++; end
    chk("accept_wait0", 64'(rdy0), 64'd1);
    if (b2b) chk("b2b_on_rsp0", 64'(rv0), 64'd1);
    e.uir  = !SKIP || !have_ir0 || (ir != last_ir0);
    e.lat  = e.uir ? 164 : 160;
    e.data = tdo_one ? {DW{1'b1}} : {data[DW-2:0], 1'b0};
    e.ir   = ir;
    have_ir0 = 1; last_ir0 = ir;
    exp_q0.push_back(e);
    step();
    if (!hold) begin
      v0 = 1'b0; ir0 = 2'($urandom); d0 = DW'({$urandom(), $urandom()});
    end
  endtask

  task automatic send1(input logic [1:0] ir, input logic [DW-1:0] data);
    exp_t e;
    int   n = 0;
    v1 = 1'b1; ir1 = ir; d1 = data;
    while (!rdy1 && n < 2000) begin step(); n++; end
    chk("accept_wait1", 64'(rdy1), 64'd1);
    e.uir = 1; e.lat = 246; e.ir = ir;
    e.data = {data[DW-2:0], 1'b0};
    exp_q1.push_back(e);
    step();
    v1 = 1'b0; ir1 = 2'($urandom); d1 = DW'({$urandom(), $urandom()});
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 3000) begin step(); n++; end
    chk("drain", 64'(exp_q0.size() + exp_q1.size()), 64'd0);
  endtask

  task automatic reset_chk0(input string tag);
    chk({tag, "_ready"}, 64'(rdy0), 64'd1);
    chk({tag, "_rsp_valid"}, 64'(rv0), 64'd0);
    chk({tag, "_rsp_data"}, 64'(rd0), 64'd0);
    chk({tag, "_tck"}, 64'(tck0), 64'd0);
    chk({tag, "_tdi"}, 64'(tdi0), 64'd0);
    chk({tag, "_ir_in"}, 64'(irin0), 64'd0);
    chk({tag, "_strobes"}, 64'({rti0, uir0, cdr0, sdr0, udr0}), 64'b10000);
  endtask

  initial begin
    int tck_hi;
    #1;
    rst0_n = 1'b0; rst1_n = 1'b0;
    #1;
    reset_chk0("reset0");
    chk("reset1_ready", 64'(rdy1), 64'd1);
    chk("reset1_tck", 64'(tck1), 64'd0);
    repeat (3) step();
    rst0_n = 1'b1; rst1_n = 1'b1;
    step();

    send0(2'd1, 38'h2A_5555_AAAA, 0, 0);
    drain();

    send0(2'd2, 38'h00_F0F0_1234, 1, 0);
    send0(2'd2, 38'h3C_0001_8000, 0, 1);
    send0(2'd3, 38'h15_DEAD_BEEF, 0, 0);
    drain();

    tdo_one = 1'b1;
    send0(2'd0, 38'h01_2345_6789, 0, 0);
    drain();
    tdo_one = 1'b0;

    send0(2'd1, 38'h2A_AAAA_5555, 0, 0);
    repeat (79) step();
    rst0_n = 1'b0;
    exp_q0.delete(); acc_q0.delete(); have_ir0 = 0;
    #1;
    reset_chk0("midscan");
    repeat (3) step();
    rst0_n = 1'b1;
    tck_hi = 0;
    repeat (6) begin step(); tck_hi += int'(tck0); end
    chk("tck_quiet_after_reset", 64'(tck_hi), 64'd0);
    send0(2'd0, 38'h33_CCCC_3333, 0, 0);
    drain();

    send1(2'd0, 38'h03_1234_5678);
    send1(2'd3, 38'h15_0F0F_F0F0);
    drain();

    repeat (4) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
